// File: rtl/msg_decrypter.sv
// ============================================================================
// msg_decrypter : recovers LFSR tap/seed from a space preamble, decrypts a
// 64-byte frame and writes the left-justified plaintext back to data memory.
// Optional feature macro: MSG_DECRYPT_PARITY_CHK_EN (per-byte parity check).
// Revision: 1.0
// ============================================================================
`default_nettype none

module msg_decrypter #(
  parameter int ENC_BASE = 64,
  parameter int OUT_BASE = 0,
  parameter int PRE_MIN  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic       Err,
  output logic [3:0] PtNo,
  output logic [6:0] Seed,
  output logic [7:0] MemAddr,
  output logic       MemRdEn,
  input  logic [7:0] MemRdData,
  output logic       MemWrEn,
  output logic [7:0] MemWrData
`ifdef MSG_DECRYPT_PARITY_CHK_EN
  ,
  output logic [6:0] ParErrCnt
`endif
);

  localparam logic [7:0] c_ENC_BASE = 8'(ENC_BASE);
  localparam logic [7:0] c_OUT_BASE = 8'(OUT_BASE);
  localparam logic [6:0] c_LAST_CHK = 7'(PRE_MIN - 1);
  localparam logic [6:0] c_SPACE    = 7'h20;
`ifdef MSG_DECRYPT_PARITY_CHK_EN
  localparam int c_EW = 8;
`else
  localparam int c_EW = 7;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SEARCH  = 3'd2,
    S_DECRYPT = 3'd3,
    S_PAD     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  function automatic logic [6:0] tap_of(input logic [3:0] idx);
    case (idx)
      4'd0:    return 7'h60;
      4'd1:    return 7'h48;
      4'd2:    return 7'h78;
      4'd3:    return 7'h72;
      4'd4:    return 7'h6A;
      4'd5:    return 7'h69;
      4'd6:    return 7'h5C;
      4'd7:    return 7'h7E;
      default: return 7'h7B;
    endcase
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] tap);
    return {s[5:0], ^(s & tap)};
  endfunction

  state_t          state_q, state_d;
  logic            start_prev_q, start_prev_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [3:0]      pt_q, pt_d;
  logic [6:0]      lfsr_q, lfsr_d;
  logic [6:0]      wp_q, wp_d;
  logic            seen_q, seen_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [3:0]      pt_no_q, pt_no_d;
  logic [6:0]      seed_q, seed_d;
  logic [c_EW-1:0] enc_q [64];
  logic [c_EW-1:0] enc_d [64];

  logic [5:0] byte_idx;
  logic [6:0] seed_w;
  logic [6:0] srch_prev;
  logic [6:0] srch_nxt;
  logic [6:0] dec_cur;
  logic [7:0] plain;
  logic [7:0] wr_byte;
  logic       par_bad;

  assign byte_idx  = cnt_q[5:0];
  assign seed_w    = enc_q[0][6:0] ^ c_SPACE;
  // Search walks i = 1..PRE_MIN-1; the state before step 1 is the seed itself.
  assign srch_prev = (cnt_q == 7'd1) ? seed_w : lfsr_q;
  assign srch_nxt  = lfsr_step(srch_prev, tap_of(pt_q));
  assign dec_cur   = (cnt_q == 7'd0) ? seed_q : lfsr_q;
  assign plain     = {1'b0, enc_q[byte_idx][6:0] ^ dec_cur};

`ifdef MSG_DECRYPT_PARITY_CHK_EN
  logic [6:0] par_cnt_q, par_cnt_d;
  assign par_bad   = enc_q[byte_idx][7] ^ (^enc_q[byte_idx][6:0]);
  assign wr_byte   = par_bad ? 8'h80 : plain;
  assign ParErrCnt = par_cnt_q;
`else
  logic unused_rd_msb;
  assign unused_rd_msb = MemRdData[7];
  assign par_bad       = 1'b0;
  assign wr_byte       = plain;
`endif

  always_comb begin
    state_d      = state_q;
    start_prev_d = Start;
    cnt_d        = cnt_q;
    pt_d         = pt_q;
    lfsr_d       = lfsr_q;
    wp_d         = wp_q;
    seen_d       = seen_q;
    ack_d        = ack_q;
    err_d        = err_q;
    pt_no_d      = pt_no_q;
    seed_d       = seed_q;
    enc_d        = enc_q;
`ifdef MSG_DECRYPT_PARITY_CHK_EN
    par_cnt_d    = par_cnt_q;
`endif
    MemAddr      = 8'h00;
    MemRdEn      = 1'b0;
    MemWrEn      = 1'b0;
    MemWrData    = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (start_prev_q && !Start) begin
          state_d = S_LOAD;
          cnt_d   = 7'd0;
`ifdef MSG_DECRYPT_PARITY_CHK_EN
          par_cnt_d = 7'd0;
`endif
        end
      end

      S_LOAD: begin
        if (cnt_q < 7'd64) begin
          MemRdEn = 1'b1;
          MemAddr = c_ENC_BASE + {2'b00, byte_idx};
        end
        // Read data lags its strobe by one cycle, hence the 65th cycle.
        if (cnt_q != 7'd0) begin
          enc_d[6'(cnt_q - 7'd1)] = MemRdData[c_EW-1:0];
        end
        if (cnt_q == 7'd64) begin
          state_d = S_SEARCH;
          cnt_d   = 7'd1;
          pt_d    = 4'd0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      S_SEARCH: begin
        if (seed_w == 7'd0) begin
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = S_DONE;
        end else if ((enc_q[byte_idx][6:0] ^ srch_nxt) == c_SPACE) begin
          if (cnt_q == c_LAST_CHK) begin
            pt_no_d = pt_q;
            seed_d  = seed_w;
            state_d = S_DECRYPT;
            cnt_d   = 7'd0;
            wp_d    = 7'd0;
            seen_d  = 1'b0;
          end else begin
            cnt_d  = cnt_q + 7'd1;
            lfsr_d = srch_nxt;
          end
        end else if (pt_q == 4'd8) begin
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          pt_d  = pt_q + 4'd1;
          cnt_d = 7'd1;
        end
      end

      S_DECRYPT: begin
        lfsr_d = lfsr_step(dec_cur, tap_of(pt_no_q));
`ifdef MSG_DECRYPT_PARITY_CHK_EN
        if (par_bad && (par_cnt_q != 7'h7F)) begin
          par_cnt_d = par_cnt_q + 7'd1;
        end
`endif
        if (seen_q || (wr_byte != 8'h20)) begin
          MemWrEn   = 1'b1;
          MemAddr   = c_OUT_BASE + {1'b0, wp_q};
          MemWrData = wr_byte;
          wp_d      = wp_q + 7'd1;
          seen_d    = 1'b1;
        end
        if (cnt_q == 7'd63) begin
          if (wp_d == 7'd64) begin
            state_d = S_DONE;
            ack_d   = 1'b1;
          end else begin
            state_d = S_PAD;
          end
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      S_PAD: begin
        MemWrEn   = 1'b1;
        MemAddr   = c_OUT_BASE + {1'b0, wp_q};
        MemWrData = 8'h20;
        wp_d      = wp_q + 7'd1;
        if (wp_q == 7'd63) begin
          state_d = S_DONE;
          ack_d   = 1'b1;
        end
      end

      S_DONE: begin
        if (Start && !start_prev_q) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
          pt_no_d = 4'd0;
          seed_d  = 7'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      cnt_q        <= 7'd0;
      pt_q         <= 4'd0;
      lfsr_q       <= 7'd0;
      wp_q         <= 7'd0;
      seen_q       <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      pt_no_q      <= 4'd0;
      seed_q       <= 7'd0;
`ifdef MSG_DECRYPT_PARITY_CHK_EN
      par_cnt_q    <= 7'd0;
`endif
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      cnt_q        <= cnt_d;
      pt_q         <= pt_d;
      lfsr_q       <= lfsr_d;
      wp_q         <= wp_d;
      seen_q       <= seen_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      pt_no_q      <= pt_no_d;
      seed_q       <= seed_d;
`ifdef MSG_DECRYPT_PARITY_CHK_EN
      par_cnt_q    <= par_cnt_d;
`endif
    end
  end

  // Frame buffer carries no reset; it is always reloaded before use.
  always_ff @(posedge Clk) begin
    enc_q <= enc_d;
  end

  assign Ack  = ack_q;
  assign Err  = err_q;
  assign PtNo = pt_no_q;
  assign Seed = seed_q;

endmodule

`default_nettype wire

// File: tb/tb_msg_decrypter.sv
// ============================================================================
// tb_msg_decrypter : directed self-checking bench for msg_decrypter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_msg_decrypter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       ack;
  logic       err;
  logic [3:0] pt_no;
  logic [6:0] seed;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
`ifdef MSG_DECRYPT_PARITY_CHK_EN
  logic [6:0] par_err_cnt;
`endif

  logic [7:0] rd_mem  [256];
  logic [7:0] out_mem [256];
  int wr_total = 0;
  int overlap_total = 0;
  int errors = 0;
  int checks = 0;
  string msg;

  msg_decrypter #(.ENC_BASE(64), .OUT_BASE(0), .PRE_MIN(10)) dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .Start     (start),
    .Ack       (ack),
    .Err       (err),
    .PtNo      (pt_no),
    .Seed      (seed),
    .MemAddr   (mem_addr),
    .MemRdEn   (mem_rd_en),
    .MemRdData (mem_rd_data),
    .MemWrEn   (mem_wr_en),
    .MemWrData (mem_wr_data)
`ifdef MSG_DECRYPT_PARITY_CHK_EN
    ,
    .ParErrCnt (par_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: writes commit at the strobed edge, reads return next cycle.
  always @(posedge clk) begin
    if (mem_wr_en) begin
      out_mem[mem_addr] <= mem_wr_data;
      wr_total <= wr_total + 1;
    end
    if (mem_rd_en) mem_rd_data <= rd_mem[mem_addr];
    if (mem_rd_en && mem_wr_en) overlap_total <= overlap_total + 1;
  end

  function automatic logic [6:0] tb_tap(input int p);
    case (p)
      0: return 7'h60;  1: return 7'h48;  2: return 7'h78;
      3: return 7'h72;  4: return 7'h6A;  5: return 7'h69;
      6: return 7'h5C;  7: return 7'h7E;  default: return 7'h7B;
    endcase
  endfunction

  function automatic logic [6:0] tb_step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  // Encrypts pre spaces + msg + trailing spaces into enc bytes at 64..127.
  task automatic build_frame(input int pre, input int pt, input logic [6:0] init);
    logic [6:0] s;
    logic [7:0] p;
    logic [6:0] c;
    s = init;
    for (int i = 0; i < 64; i++) begin
      if (i < pre || (i - pre) >= msg.len()) p = 8'h20;
      else p = msg[i-pre];
      c = p[6:0] ^ s;
      rd_mem[64+i] = {^c, c};
      s = tb_step(s, tb_tap(pt));
    end
  endtask

  task automatic launch_and_wait(output int lat, output bit timed_out);
    @(negedge clk);
    start = 1'b0;
    timed_out = 1'b1;
    lat = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        lat = k;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic release_run;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({ack, err} !== 2'b00) begin errors++; $display("FAIL reset_ack_err: got %b required 00", {ack, err}); end
    checks++; if ({pt_no, seed} !== 11'd0) begin errors++; $display("FAIL reset_pt_seed: got %0h/%0h required 0/0", pt_no, seed); end
    checks++; if ({mem_rd_en, mem_wr_en, mem_addr, mem_wr_data} !== 18'd0) begin errors++; $display("FAIL reset_mem_port: got rd=%b wr=%b a=%0h d=%0h required all 0", mem_rd_en, mem_wr_en, mem_addr, mem_wr_data); end
`ifdef MSG_DECRYPT_PARITY_CHK_EN
    checks++; if (par_err_cnt !== 7'd0) begin errors++; $display("FAIL reset_parcnt: got %0d required 0", par_err_cnt); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic_pt3;
    int lat, w0, bad, sp;
    bit to;
    build_frame(10, 3, 7'h01);
    w0 = wr_total;
    launch_and_wait(lat, to);
    checks++; if (to) begin errors++; $display("FAIL pt3_ack_timeout: got no Ack required Ack"); end
    checks++; if (pt_no !== 4'd3) begin errors++; $display("FAIL pt3_ptno: got %0d required 3", pt_no); end
    checks++; if (seed !== 7'h01) begin errors++; $display("FAIL pt3_seed: got %0h required 01", seed); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL pt3_err: got %b required 0", err); end
    checks++; if (out_mem[0] !== 8'h4D) begin errors++; $display("FAIL pt3_mem0: got %0h required 4d", out_mem[0]); end
    checks++; if (out_mem[40] !== 8'h2E) begin errors++; $display("FAIL pt3_mem40: got %0h required 2e", out_mem[40]); end
    bad = 0; sp = 0;
    for (int k = 0; k < 41; k++) if (out_mem[k] !== 8'(msg[k])) bad++;
    for (int k = 41; k < 64; k++) if (out_mem[k] !== 8'h20) sp++;
    checks++; if (bad != 0) begin errors++; $display("FAIL pt3_text: got %0d wrong bytes required 0", bad); end
    checks++; if (sp != 0) begin errors++; $display("FAIL pt3_pad: got %0d non-space bytes required 0", sp); end
    checks++; if (wr_total - w0 != 64) begin errors++; $display("FAIL pt3_wr_count: got %0d required 64", wr_total - w0); end
    checks++; if (overlap_total != 0) begin errors++; $display("FAIL pt3_rd_wr_overlap: got %0d required 0", overlap_total); end
    release_run();
    checks++; if ({ack, err, pt_no, seed} !== 13'd0) begin errors++; $display("FAIL pt3_clear: got ack=%b err=%b pt=%0d seed=%0h required all 0", ack, err, pt_no, seed); end
  endtask

  task automatic test_pt8_pre15;
    int lat, w0, bad;
    bit to;
    build_frame(15, 8, 7'h7F);
    w0 = wr_total;
    launch_and_wait(lat, to);
    checks++; if (to) begin errors++; $display("FAIL pt8_ack_timeout: got no Ack required Ack"); end
    checks++; if ({pt_no, seed} !== {4'd8, 7'h7F}) begin errors++; $display("FAIL pt8_pt_seed: got %0d/%0h required 8/7f", pt_no, seed); end
    bad = 0;
    for (int k = 0; k < 41; k++) if (out_mem[k] !== 8'(msg[k])) bad++;
    for (int k = 41; k < 64; k++) if (out_mem[k] !== 8'h20) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL pt8_text: got %0d wrong bytes required 0", bad); end
    checks++; if (wr_total - w0 != 64) begin errors++; $display("FAIL pt8_wr_count: got %0d required 64", wr_total - w0); end
    release_run();
  endtask

  task automatic test_seed_zero;
    int lat, w0;
    bit to;
    build_frame(10, 3, 7'h00);
    w0 = wr_total;
    launch_and_wait(lat, to);
    checks++; if (to || lat > 66) begin errors++; $display("FAIL seed0_ack_latency: got %0d (timeout=%b) required <=66", lat, to); end
    checks++; if ({ack, err} !== 2'b11) begin errors++; $display("FAIL seed0_ack_err: got %b required 11", {ack, err}); end
    checks++; if (wr_total - w0 != 0) begin errors++; $display("FAIL seed0_writes: got %0d required 0", wr_total - w0); end
    release_run();
  endtask

  task automatic test_no_match;
    int lat, w0;
    bit to, hit;
    logic [6:0] s, v, forb [9];
    build_frame(10, 3, 7'h01);
    for (int p = 0; p < 9; p++) begin
      s = 7'h01;
      for (int i = 0; i < 5; i++) s = tb_step(s, tb_tap(p));
      forb[p] = s ^ 7'h20;
    end
    v = 7'h00;
    for (int c = 0; c < 128; c++) begin
      hit = 1'b0;
      for (int p = 0; p < 9; p++) if (forb[p] == 7'(c)) hit = 1'b1;
      if (!hit) begin v = 7'(c); break; end
    end
    rd_mem[64+5] = {^v, v};
    w0 = wr_total;
    launch_and_wait(lat, to);
    checks++; if (to) begin errors++; $display("FAIL nomatch_ack_timeout: got no Ack required Ack"); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL nomatch_err: got %b required 1", err); end
    checks++; if (lat < 74 || lat > 146) begin errors++; $display("FAIL nomatch_latency: got %0d required 74..146", lat); end
    checks++; if (wr_total - w0 != 0) begin errors++; $display("FAIL nomatch_writes: got %0d required 0", wr_total - w0); end
    checks++; if ({pt_no, seed} !== 11'd0) begin errors++; $display("FAIL nomatch_pt_seed: got %0d/%0h required 0/0", pt_no, seed); end
    release_run();
  endtask

  task automatic test_reset_mid_run;
    int lat, w0, bad;
    bit to, seen_wr;
    build_frame(10, 3, 7'h01);
    @(negedge clk);
    start = 1'b0;
    seen_wr = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (mem_wr_en === 1'b1) begin seen_wr = 1'b1; break; end
    end
    checks++; if (!seen_wr) begin errors++; $display("FAIL midrst_no_write: got no write strobe required one"); end
    repeat (5) @(negedge clk);
    checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL midrst_precond_wr: got %b required 1", mem_wr_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_wr_en, mem_rd_en, mem_addr} !== 10'd0) begin errors++; $display("FAIL midrst_strobe_drop: got wr=%b rd=%b a=%0h required 0", mem_wr_en, mem_rd_en, mem_addr); end
    checks++; if ({ack, err, pt_no, seed} !== 13'd0) begin errors++; $display("FAIL midrst_outputs: got ack=%b err=%b pt=%0d seed=%0h required all 0", ack, err, pt_no, seed); end
    w0 = wr_total;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wr_total != w0) begin errors++; $display("FAIL midrst_writes_in_reset: got %0d required 0", wr_total - w0); end
    rst_n = 1'b1;
    @(negedge clk);
    build_frame(15, 8, 7'h7F);
    w0 = wr_total;
    launch_and_wait(lat, to);
    checks++; if (to || {pt_no, seed, err} !== {4'd8, 7'h7F, 1'b0}) begin errors++; $display("FAIL midrst_relaunch: got pt=%0d seed=%0h err=%b timeout=%b required 8/7f/0/0", pt_no, seed, err, to); end
    bad = 0;
    for (int k = 0; k < 41; k++) if (out_mem[k] !== 8'(msg[k])) bad++;
    checks++; if (bad != 0 || wr_total - w0 != 64) begin errors++; $display("FAIL midrst_relaunch_text: got %0d bad bytes %0d writes required 0/64", bad, wr_total - w0); end
    release_run();
  endtask

`ifdef MSG_DECRYPT_PARITY_CHK_EN
  task automatic test_parity;
    int lat, bad;
    bit to;
    build_frame(10, 3, 7'h01);
    rd_mem[64+13][7] = ~rd_mem[64+13][7];
    launch_and_wait(lat, to);
    checks++; if (to) begin errors++; $display("FAIL par_ack_timeout: got no Ack required Ack"); end
    checks++; if (out_mem[3] !== 8'h80) begin errors++; $display("FAIL par_mem3: got %0h required 80", out_mem[3]); end
    checks++; if (par_err_cnt !== 7'd1) begin errors++; $display("FAIL par_count: got %0d required 1", par_err_cnt); end
    bad = 0;
    for (int k = 0; k < 41; k++) if (k != 3 && out_mem[k] !== 8'(msg[k])) bad++;
    for (int k = 41; k < 64; k++) if (out_mem[k] !== 8'h20) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL par_other_bytes: got %0d wrong required 0", bad); end
    release_run();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    msg = "Mr. Watson, come here. I want to see you.";
    rst_n = 1'b0;
    start = 1'b1;
    test_reset();
    test_basic_pt3();
    test_pt8_pre15();
    test_seed_zero();
    test_no_match();
    test_reset_mid_run();
`ifdef MSG_DECRYPT_PARITY_CHK_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/msg_decrypter.md
# msg_decrypter

Hardware decryption engine for the LFSR message cipher. It reads a 64-byte encrypted frame from data memory and recovers the LFSR tap pattern and starting state from the known space-character preamble. It then decrypts the frame, strips the leading spaces, and writes the plaintext back to data memory. It sits beside the processor core as a memory-mapped accelerator and shares the data-memory port with the core while `Ack` is low.

## Interface
Parameters:
- `ENC_BASE`, 64: data-memory address of encrypted byte 0.
- `OUT_BASE`, 0: data-memory address of plaintext byte 0.
- `PRE_MIN`, 10: guaranteed minimum preamble length; bytes 1..`PRE_MIN`-1 are used for the pattern search.

Ports:
- `Clk`, input, 1: sole clock, rising-edge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `Start`, input, 1: launch request.
- `Ack`, output, 1: run complete.
- `Err`, output, 1: no pattern matched, or seed illegal.
- `PtNo`, output, 4: index 0..8 of the recovered tap pattern.
- `Seed`, output, 7: recovered LFSR starting state.
- `MemAddr`, output, 8: data-memory address.
- `MemRdEn`, output, 1: read strobe; data returns on `MemRdData` the next cycle.
- `MemRdData`, input, 8: read data.
- `MemWrEn`, output, 1: write strobe; the write commits at this rising edge.
- `MemWrData`, output, 8: write data.
- `ParErrCnt`, output, 7: parity-error count. Present only with `MSG_DECRYPT_PARITY_CHK_EN`.

## Operation
- Tap table, index 0..8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- LFSR step: next = {s[5:0], ^(s & tap)}.
- States: IDLE → LOAD → SEARCH → DECRYPT → PAD → DONE.
- IDLE:
  - Held while `Start` = 1.
  - Launches on the first cycle `Start` = 0 after having been 1.
- LOAD:
  - Reads addresses `ENC_BASE`..`ENC_BASE`+63 into a 64×8 internal buffer, one read per cycle.
- SEARCH:
  - Seed = enc[0][6:0] ^ 7'h20.
  - If Seed = 0: set `Err`, go to DONE, perform no writes.
  - For pt = 0..8 in order:
    - Step the LFSR from Seed once per cycle.
    - For each i = 1..`PRE_MIN`-1, check enc[i][6:0] ^ lfsr_i == 7'h20.
    - On the first mismatch, abandon this pt.
  - The lowest pt that passes all checks wins: latch `PtNo` and `Seed`.
  - If no pt passes: set `Err` and go to DONE.
- DECRYPT:
  - Regenerate the LFSR from Seed. For i = 0..63, one byte per cycle, plain = {1'b0, enc[i][6:0] ^ lfsr_i}.
  - Bytes equal to 0x20 that occur before the first non-space byte are dropped.
  - Every later byte, spaces included, is written to `OUT_BASE`+wp, then wp increments.
- PAD:
  - Writes 0x20 at `OUT_BASE`+wp until wp = 64. Exactly 64 writes total per successful run.
- DONE:
  - `Ack` = 1, held until `Start` rises again.
  - `Start` rising in DONE clears `Ack`, `Err`, `PtNo`, `Seed` and returns to IDLE.
- Enc bit 7 (parity) is ignored everywhere except by the parity check feature.

## Timing
- Reset values: state IDLE; `Ack`, `Err`, `MemRdEn`, `MemWrEn` = 0; `PtNo` = 0; `Seed` = 0; `MemAddr` = 0; `MemWrData` = 0; `ParErrCnt` = 0.
- Reset asserted mid-run: immediate return to IDLE. Any write strobe drops asynchronously, and no further memory access occurs.
- LOAD: 65 cycles (64 reads plus 1 cycle of read latency).
- SEARCH:
  - Each candidate costs 1 to `PRE_MIN`-1 cycles; early exit on mismatch.
  - Worst case 9×(`PRE_MIN`-1) = 81 cycles.
  - Seed = 0 costs 1 cycle.
- DECRYPT + PAD: 64 + (number of leading spaces) cycles. Writes are never issued on the same cycle as a read.
- `Ack` rises the cycle after the last write, or the cycle after `Err` is set.
- Read and write strobes are mutually exclusive; `MemAddr` is only meaningful while a strobe is high.

## Configuration
- `MSG_DECRYPT_PARITY_CHK_EN` defined:
  - In DECRYPT, each enc[i] with enc[i][7] ≠ ^enc[i][6:0] increments `ParErrCnt`, saturating at 127.
  - If that byte is written, the value written is 0x80 instead of the decrypted character. An erroneous byte counts as non-space for leading-space stripping.
  - `ParErrCnt` clears at launch.
- Not defined:
  - The `ParErrCnt` port and its logic are absent.
  - Parity is ignored and the decrypted value is always written.

## Test plan
- "Mr. Watson, come here. I want to see you." encrypted with preamble 10, pt 3, init 0x01 → `PtNo` = 3, `Seed` = 0x01, mem[0] = 0x4D, mem[40] = 0x2E, mem[41..63] = 0x20, `Err` = 0, `Ack` = 1.
- Same message with preamble 15, pt 8, init 0x7F → `PtNo` = 8, mem[0..40] identical to the previous case, exactly 64 writes.
- enc[0][6:0] = 0x20 (Seed 0) → `Err` = 1, `Ack` = 1, zero writes, `Ack` within 66 cycles of launch.
- Frame whose byte 5 breaks every pattern → `Err` = 1 after 9 candidates, no writes.
- Reset pulled low mid-DECRYPT, then a relaunch with a valid frame → outputs at reset values, then correct output after the relaunch.
- With `MSG_DECRYPT_PARITY_CHK_EN`, bit 7 of message byte 3 (enc[13]) flipped → mem[3] = 0x80, `ParErrCnt` = 1, all other bytes correct.
